// File: rtl/v_table_init_ctrl.sv
// v_table_init_ctrl: reset-init sweep, write forwarding and ranged flush for replicated state tables.
// Optional protocol checking (sticky o_err_r) is built when V_TABLE_INIT_CHECK_EN is defined.
module v_table_init_ctrl #(
    parameter int N = 128,
    parameter int W = 64,
    parameter int BANKS_N = 2,
    parameter logic [W-1:0] INIT_VAL = '0,
    localparam int AW = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_wen,
    input  logic [AW-1:0]      i_waddr,
    input  logic [W-1:0]       i_wdata,
    input  logic               i_flush_vld,
    input  logic [AW-1:0]      i_flush_lo,
    input  logic [AW-1:0]      i_flush_hi,
    output logic               o_flush_rdy_r,
    output logic               o_flush_done_r,
    output logic [BANKS_N-1:0] o_wen_r,
    output logic [AW-1:0]      o_waddr_r,
    output logic [W-1:0]       o_wdata_r,
    output logic               o_busy_r,
    output logic               o_err_r
);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_FLUSH
    } state_t;

    localparam logic [AW:0] LAST = (AW+1)'(N - 1);
    localparam logic [AW:0] ONE  = (AW+1)'(1);

    state_t             state_q;
    state_t             state_d;
    logic [AW:0]        cnt_q;
    logic [AW:0]        cnt_d;
    logic [AW-1:0]      hi_q;
    logic [AW-1:0]      hi_d;
    logic [BANKS_N-1:0] wen_d;
    logic [AW-1:0]      waddr_d;
    logic [W-1:0]       wdata_d;
    logic               busy_d;
    logic               rdy_d;
    logic               done_d;

    logic               accept;
    logic [AW-1:0]      hi_clamp;
    logic               range_empty;
    logic               range_last;

    assign accept   = (state_q == ST_IDLE) && i_flush_vld && o_flush_rdy_r;
    assign hi_clamp = ({1'b0, i_flush_hi} > LAST) ? LAST[AW-1:0] : i_flush_hi;

    // cnt is one bit wider than an address so a sweep past hi never wraps
    assign range_empty = cnt_q > {1'b0, hi_q};
    assign range_last  = cnt_q == {1'b0, hi_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        wen_d   = '0;
        waddr_d = o_waddr_r;
        wdata_d = o_wdata_r;
        busy_d  = (state_q == ST_INIT);
        rdy_d   = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                wen_d   = '1;
                waddr_d = cnt_q[AW-1:0];
                wdata_d = INIT_VAL;
                cnt_d   = cnt_q + ONE;
                if (cnt_q == LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                rdy_d = !accept;
                if (i_wen) begin
                    wen_d   = '1;
                    waddr_d = i_waddr;
                    wdata_d = i_wdata;
                end
                if (accept) begin
                    cnt_d   = {1'b0, i_flush_lo};
                    hi_d    = hi_clamp;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (i_wen) begin
                    wen_d   = '1;
                    waddr_d = i_waddr;
                    wdata_d = i_wdata;
                end
                // functional writes win; the sweep only advances on free cycles
                if (range_empty) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else if (!i_wen) begin
                    wen_d   = '1;
                    waddr_d = cnt_q[AW-1:0];
                    wdata_d = INIT_VAL;
                    cnt_d   = cnt_q + ONE;
                    if (range_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_INIT;
            cnt_q          <= '0;
            hi_q           <= '0;
            o_wen_r        <= '0;
            o_waddr_r      <= '0;
            o_wdata_r      <= '0;
            o_busy_r       <= 1'b1;
            o_flush_rdy_r  <= 1'b0;
            o_flush_done_r <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            hi_q           <= hi_d;
            o_wen_r        <= wen_d;
            o_waddr_r      <= waddr_d;
            o_wdata_r      <= wdata_d;
            o_busy_r       <= busy_d;
            o_flush_rdy_r  <= rdy_d;
            o_flush_done_r <= done_d;
        end
    end

`ifdef V_TABLE_INIT_CHECK_EN
    logic err_init_wen;
    logic err_range;
    logic err_early;

    assign err_init_wen = (state_q == ST_INIT) && i_wen;
    assign err_range    = accept && ((i_flush_lo > i_flush_hi) ||
                                     ({1'b0, i_flush_hi} > LAST));
    assign err_early    = (state_q == ST_INIT) && i_flush_vld && !o_flush_rdy_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            o_err_r <= 1'b0;
        end else if (err_init_wen || err_range || err_early) begin
            o_err_r <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (err_init_wen) begin
                $error("v_table_init_ctrl: write during init sweep");
            end
            if (err_range) begin
                $error("v_table_init_ctrl: flush range lo>hi or hi>N-1");
            end
            if (err_early) begin
                $error("v_table_init_ctrl: flush request during init sweep");
            end
        end
    end
`endif
`else
    assign o_err_r = 1'b0;
`endif

endmodule

// File: tb/tb_v_table_init_ctrl.sv
// tb_v_table_init_ctrl: directed and random stimulus against a queue-based model
// of the init sweep, write forwarding and ranged flush.
module tb_v_table_init_ctrl;

    localparam int N  = 8;
    localparam int W  = 16;
    localparam int BN = 2;
    localparam int AW = 3;
    localparam logic [W-1:0] IV = 16'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_wen;
    logic [AW-1:0] i_waddr;
    logic [W-1:0]  i_wdata;
    logic          i_flush_vld;
    logic [AW-1:0] i_flush_lo;
    logic [AW-1:0] i_flush_hi;
    logic          o_flush_rdy_r;
    logic          o_flush_done_r;
    logic [BN-1:0] o_wen_r;
    logic [AW-1:0] o_waddr_r;
    logic [W-1:0]  o_wdata_r;
    logic          o_busy_r;
    logic          o_err_r;

    always #5 clk = ~clk;

    v_table_init_ctrl #(
        .N(N), .W(W), .BANKS_N(BN), .INIT_VAL(IV)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_wen(i_wen),
        .i_waddr(i_waddr),
        .i_wdata(i_wdata),
        .i_flush_vld(i_flush_vld),
        .i_flush_lo(i_flush_lo),
        .i_flush_hi(i_flush_hi),
        .o_flush_rdy_r(o_flush_rdy_r),
        .o_flush_done_r(o_flush_done_r),
        .o_wen_r(o_wen_r),
        .o_waddr_r(o_waddr_r),
        .o_wdata_r(o_wdata_r),
        .o_busy_r(o_busy_r),
        .o_err_r(o_err_r)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Model: pending sweep addresses held in a queue
    int         sweep[$];
    bit         initing;
    bit         flushing;
    bit         m_busy;
    bit         m_rdy;
    bit         m_err;
    bit         e_wen;
    bit         e_done;
    int         e_addr;
    logic [W-1:0] e_data;

    task automatic step(input bit r, input bit wen, input int wa,
                        input logic [W-1:0] wd, input bit fv,
                        input int lo, input int hi);
        bit was_init;
        bit was_idle;
        bit acc;
        int hc;
        rst         = r;
        i_wen       = wen;
        i_waddr     = wa[AW-1:0];
        i_wdata     = wd;
        i_flush_vld = fv;
        i_flush_lo  = lo[AW-1:0];
        i_flush_hi  = hi[AW-1:0];
        e_wen  = 1'b0;
        e_done = 1'b0;
        if (r) begin
            sweep.delete();
            for (int a = 0; a < N; a++) sweep.push_back(a);
            initing  = 1'b1;
            flushing = 1'b0;
            m_busy   = 1'b1;
            m_rdy    = 1'b0;
            m_err    = 1'b0;
        end else begin
            was_init = initing;
            was_idle = !initing && !flushing;
            acc      = was_idle && fv && m_rdy;
            if (initing) begin
`ifdef V_TABLE_INIT_CHECK_EN
                if (wen || (fv && !m_rdy)) m_err = 1'b1;
`endif
                e_wen  = 1'b1;
                e_addr = sweep.pop_front();
                e_data = IV;
                if (sweep.size() == 0) initing = 1'b0;
            end else if (flushing) begin
                if (wen) begin
                    e_wen  = 1'b1;
                    e_addr = wa;
                    e_data = wd;
                end
                if (sweep.size() == 0) begin
                    e_done   = 1'b1;
                    flushing = 1'b0;
                end else if (!wen) begin
                    e_wen  = 1'b1;
                    e_addr = sweep.pop_front();
                    e_data = IV;
                    if (sweep.size() == 0) begin
                        e_done   = 1'b1;
                        flushing = 1'b0;
                    end
                end
            end else begin
                if (wen) begin
                    e_wen  = 1'b1;
                    e_addr = wa;
                    e_data = wd;
                end
                if (acc) begin
                    hc = (hi > N - 1) ? N - 1 : hi;
                    for (int a = lo; a <= hc; a++) sweep.push_back(a);
                    flushing = 1'b1;
`ifdef V_TABLE_INIT_CHECK_EN
                    if (lo > hi || hi > N - 1) m_err = 1'b1;
`endif
                end
            end
            m_busy = was_init;
            m_rdy  = was_idle && !acc;
        end
        @(posedge clk);
        #1;
        check("wen", o_wen_r, e_wen ? 64'h3 : 64'h0);
        if (e_wen) begin
            check("waddr", o_waddr_r, e_addr);
            check("wdata", o_wdata_r, e_data);
        end
        check("done", o_flush_done_r, e_done);
        check("busy", o_busy_r, m_busy);
        check("rdy", o_flush_rdy_r, m_rdy);
        check("err", o_err_r, m_err);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, '0, 0, 0, 0);
    endtask

    bit           rr;
    bit           rw;
    bit           rf;
    int           ra;
    int           rlo;
    int           rhi;
    logic [W-1:0] rd;

    initial begin
        // reset and full init sweep
        step(1, 0, 0, '0, 0, 0, 0);
        step(1, 0, 0, '0, 0, 0, 0);
        idle(10);
        // single functional write
        step(0, 1, 3, 16'hABCD, 0, 0, 0);
        idle(2);
        // flush 2..4
        step(0, 0, 0, '0, 1, 2, 4);
        idle(5);
        // flush 2..4 with a write in the 2nd flush cycle
        step(0, 0, 0, '0, 1, 2, 4);
        step(0, 0, 0, '0, 0, 0, 0);
        step(0, 1, 7, 16'h1111, 0, 0, 0);
        idle(4);
        // empty range and single-entry range
        step(0, 0, 0, '0, 1, 6, 2);
        idle(3);
        step(0, 0, 0, '0, 1, 5, 5);
        idle(3);
        // full range
        step(0, 0, 0, '0, 1, 0, 7);
        idle(10);
        // reset mid-init with a flush held pending
        step(1, 0, 0, '0, 0, 0, 0);
        idle(5);
        step(1, 0, 0, '0, 1, 1, 3);
        for (int k = 0; k < 14; k++) step(0, 0, 0, '0, 1, 1, 3);
        idle(4);
        // reset mid-flush discards it without a done pulse
        step(0, 0, 0, '0, 1, 0, 7);
        idle(3);
        step(1, 0, 0, '0, 0, 0, 0);
        idle(12);
        // random traffic
        for (int n = 0; n < 800; n++) begin
            rr  = ($urandom_range(0, 199) == 0);
            rw  = m_busy ? ($urandom_range(0, 15) == 0)
                         : ($urandom_range(0, 2) == 0);
            rf  = ($urandom_range(0, 4) == 0);
            ra  = $urandom_range(0, N - 1);
            rlo = $urandom_range(0, N - 1);
            rhi = $urandom_range(0, N - 1);
            rd  = W'($urandom);
            step(rr, rw, ra, rd, rf, rlo, rhi);
        end
        idle(12);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
